bcd_alu: RTL and testbench



---
 rtl/bcd_alu_pkg.sv | 22 ++
 rtl/bcd_alu_if.sv | 14 +
 rtl/bcd_digit_adder.sv | 29 ++
 rtl/bcd_alu.sv | 92 +++++++++
 tb/tb_bcd_alu.sv | 138 +++++++++++++
 5 files changed

// File: rtl/bcd_alu_pkg.sv
// bcd_alu_pkg: shared opcodes, widths and helpers for the two-digit BCD ALU.
// Latency: none (types and constants only).
// Backpressure: none.
package bcd_alu_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int RESULT_W    = 9;
  localparam logic [RESULT_W-1:0] ERR_RESULT = 9'h1FF;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_PASS = 3'b011
  } opcode_e;

  // True when a packed digit holds a non-decimal code (10..15).
  function automatic logic is_bad_digit(input logic [BCD_DIGIT_W-1:0] d);
    return (d > 4'd9);
  endfunction

endpackage

// File: rtl/bcd_alu_if.sv
// bcd_alu_if: operand/opcode/result bundle between operand regs and the ALU.
// Latency: none (wires only).
// Backpressure: none; no handshake, values may change every cycle.
interface bcd_alu_if;
  import bcd_alu_pkg::*;

  logic [RESULT_W-1:0] op1;
  logic [RESULT_W-1:0] op2;
  logic [2:0]          opcode;
  logic [RESULT_W-1:0] result;

  modport master (output op1, op2, opcode, input result);
  modport slave  (input op1, op2, opcode, output result);
endinterface

// File: rtl/bcd_digit_adder.sv
// bcd_digit_adder: one BCD digit add with +6 decimal correction.
// Latency: combinational.
// Backpressure: none.
module bcd_digit_adder
  import bcd_alu_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] a_i,
  input  logic [BCD_DIGIT_W-1:0] b_i,
  input  logic                   cin_i,
  output logic [BCD_DIGIT_W-1:0] sum_o,
  output logic                   cout_o
);

  logic [BCD_DIGIT_W:0] bin_sum;
  logic [BCD_DIGIT_W:0] corr_sum;

  // Binary sum, then skip the six unused codes when it overflows a decimal digit.
  always_comb begin
    bin_sum  = {1'b0, a_i} + {1'b0, b_i} + {{BCD_DIGIT_W{1'b0}}, cin_i};
    corr_sum = bin_sum;
    cout_o   = 1'b0;
    if (bin_sum > 5'd9) begin
      corr_sum = bin_sum + 5'd6;
      cout_o   = 1'b1;
    end
    sum_o = corr_sum[BCD_DIGIT_W-1:0];
  end

endmodule

// File: rtl/bcd_alu.sv
// bcd_alu: two-digit packed-BCD add/sub/pass unit with registered 9-bit result.
// Latency: 1 cycle (inputs sampled at a rising edge appear on result after it).
// Backpressure: none. Optional build macro BCD_ALU_DIGIT_CHECK_EN flags non-BCD digits.
module bcd_alu
  import bcd_alu_pkg::*;
#(
  parameter int ALU_SIZE_BITS = 9
) (
  input  logic clk,
  input  logic rst,
  bcd_alu_if.slave bus
);

  logic [BCD_DIGIT_W-1:0] a_units, a_tens;
  logic [BCD_DIGIT_W-1:0] b_units, b_tens;
  logic [BCD_DIGIT_W-1:0] sum_units, sum_tens;
  logic                   carry_units, carry_tens;
  logic                   is_sub;
  logic                   digit_err;
  logic                   unused_sign_bits;

  logic [ALU_SIZE_BITS-1:0] result_d, result_q;

  // Operand bit 8 carries no meaning on the input side.
  assign unused_sign_bits = bus.op1[8] ^ bus.op2[8];

  assign is_sub  = (bus.opcode == OP_SUB);
  assign a_units = bus.op1[3:0];
  assign a_tens  = bus.op1[7:4];

  // Subtraction reuses the adder: B digits become nines-complement, units cin = 1.
  always_comb begin
    b_units = bus.op2[3:0];
    b_tens  = bus.op2[7:4];
    if (is_sub) begin
      b_units = 4'd9 - bus.op2[3:0];
      b_tens  = 4'd9 - bus.op2[7:4];
    end
  end

  bcd_digit_adder u_units (
    .a_i    (a_units),
    .b_i    (b_units),
    .cin_i  (is_sub),
    .sum_o  (sum_units),
    .cout_o (carry_units)
  );

  bcd_digit_adder u_tens (
    .a_i    (a_tens),
    .b_i    (b_tens),
    .cin_i  (carry_units),
    .sum_o  (sum_tens),
    .cout_o (carry_tens)
  );

`ifdef BCD_ALU_DIGIT_CHECK_EN
  assign digit_err = is_bad_digit(bus.op1[3:0]) | is_bad_digit(bus.op1[7:4]) |
                     is_bad_digit(bus.op2[3:0]) | is_bad_digit(bus.op2[7:4]);
`else
  assign digit_err = 1'b0;
`endif

  // Next result per opcode; NOP holds, reserved opcodes clear.
  always_comb begin
    result_d = result_q;
    case (bus.opcode)
      OP_NOP:  result_d = result_q;
      OP_ADD:  result_d = {carry_tens, sum_tens, sum_units};
      // A missing tens carry means the difference went below zero and the
      // digits already hold the ten's complement.
      OP_SUB:  result_d = {~carry_tens, sum_tens, sum_units};
      OP_PASS: result_d = {1'b0, bus.op1[7:0]};
      default: result_d = '0;
    endcase
    if (digit_err && (bus.opcode == OP_ADD || bus.opcode == OP_SUB || bus.opcode == OP_PASS)) begin
      result_d = ERR_RESULT;
    end
  end

  // Result register; reset wins over every opcode.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign bus.result = result_q;

endmodule

// File: tb/tb_bcd_alu.sv
// tb_bcd_alu: directed and random checks of bcd_alu against a decimal model.
// Latency: expects result one rising edge after inputs are driven.
// Backpressure: none.
module tb_bcd_alu;
  import bcd_alu_pkg::*;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  logic [8:0] exp_q[$];
  string      tag_q[$];
  logic [8:0] model_last;

  bcd_alu_if bus ();

  bcd_alu #(.ALU_SIZE_BITS(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] t, u;
    t = 4'(n / 10);
    u = 4'(n % 10);
    return {t, u};
  endfunction

  // Decimal reference: converts digits to integers and does real arithmetic.
  function automatic logic [8:0] model(input logic r, input logic [2:0] opc,
                                       input logic [8:0] a, input logic [8:0] b,
                                       input logic [8:0] last);
    int av, bv, s;
    av = int'(a[7:4]) * 10 + int'(a[3:0]);
    bv = int'(b[7:4]) * 10 + int'(b[3:0]);
    if (r) return 9'h000;
`ifdef BCD_ALU_DIGIT_CHECK_EN
    if ((opc == 3'b001 || opc == 3'b010 || opc == 3'b011) &&
        (a[7:4] > 9 || a[3:0] > 9 || b[7:4] > 9 || b[3:0] > 9))
      return 9'h1FF;
`endif
    case (opc)
      3'b000: return last;
      3'b001: begin
        s = av + bv;
        return {(s >= 100), to_bcd(s % 100)};
      end
      3'b010: begin
        s = av - bv;
        if (s < 0) return {1'b1, to_bcd(100 + s)};
        return {1'b0, to_bcd(s)};
      end
      3'b011: return {1'b0, a[7:0]};
      default: return 9'h000;
    endcase
  endfunction

  task automatic step(input logic r, input logic [2:0] opc, input logic [8:0] a,
                      input logic [8:0] b, input string tag);
    logic [8:0] exp_v;
    logic [8:0] obs;
    string      t;
    @(negedge clk);
    rst        = r;
    bus.opcode = opc;
    bus.op1    = a;
    bus.op2    = b;
    exp_v      = model(r, opc, a, b, model_last);
    model_last = exp_v;
    exp_q.push_back(exp_v);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    obs   = bus.result;
    exp_v = exp_q.pop_front();
    t     = tag_q.pop_front();
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", t, obs, exp_v);
    end
  endtask

  initial begin
    logic [8:0] ra, rb;
    logic [2:0] ro;
    tests_run    = 0;
    tests_failed = 0;
    model_last   = 9'h000;
    rst          = 1'b1;
    bus.op1      = 9'h000;
    bus.op2      = 9'h000;
    bus.opcode   = 3'b000;

    step(1'b1, 3'b000, 9'h000, 9'h000, "reset_nop");
    step(1'b0, 3'b001, 9'h037, 9'h012, "add_37_12");
    step(1'b0, 3'b000, 9'h055, 9'h066, "nop_hold");
    step(1'b0, 3'b001, 9'h015, 9'h005, "add_15_05");
    step(1'b0, 3'b001, 9'h081, 9'h081, "add_81_81");
    step(1'b0, 3'b001, 9'h199, 9'h199, "add_99_99");
    step(1'b0, 3'b010, 9'h086, 9'h055, "sub_86_55");
    step(1'b0, 3'b010, 9'h021, 9'h033, "sub_21_33");
    step(1'b0, 3'b010, 9'h050, 9'h050, "sub_50_50");
    step(1'b0, 3'b010, 9'h000, 9'h001, "sub_00_01");
    step(1'b0, 3'b010, 9'h090, 9'h009, "sub_90_09");
    step(1'b0, 3'b011, 9'h195, 9'h042, "pass_95");
    step(1'b0, 3'b000, 9'h011, 9'h022, "nop_after_pass");
    step(1'b0, 3'b101, 9'h037, 9'h012, "reserved_101");
    step(1'b0, 3'b001, 9'h037, 9'h012, "add_before_rst");
    step(1'b0, 3'b111, 9'h099, 9'h099, "reserved_111");
    step(1'b0, 3'b001, 9'h044, 9'h044, "add_44_44");
    step(1'b1, 3'b001, 9'h037, 9'h012, "rst_during_add");
    step(1'b0, 3'b001, 9'h037, 9'h012, "add_after_rst");
    step(1'b1, 3'b011, 9'h077, 9'h000, "rst_during_pass");
    step(1'b0, 3'b000, 9'h077, 9'h000, "nop_after_rst");
`ifdef BCD_ALU_DIGIT_CHECK_EN
    step(1'b0, 3'b001, 9'h0A1, 9'h001, "chk_add_bad");
    step(1'b0, 3'b010, 9'h012, 9'h00F, "chk_sub_bad");
    step(1'b0, 3'b011, 9'h0B0, 9'h000, "chk_pass_bad");
`endif

    for (int i = 0; i < 40; i++) begin
      ra = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      rb = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      ro = 3'($urandom_range(0, 4));
      step(1'b0, ro, ra, rb, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
